// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
// Elements: E0 up w0, E1 up r0w1, E2 up r1w0, E3 dn r0w1, E4 dn r1w0, E5 up r0.
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  localparam logic OP_R = 1'b0;
  localparam logic OP_W = 1'b1;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == E3) || (e == E4);
  endfunction

  function automatic logic [1:0] elem_nops(input logic [2:0] e);
    return ((e == E0) || (e == E5)) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic elem_op(
    input logic [2:0] e,
    input logic       idx
  );
    logic op;
    op = idx ? OP_W : OP_R;
    if (e == E0) op = OP_W;
    if (e == E5) op = OP_R;
    return op;
  endfunction

  // Background bit for op idx: read expects the old value, write sets the new one.
  function automatic logic elem_bg(
    input logic [2:0] e,
    input logic       idx
  );
    logic bg;
    bg = 1'b0;
    if ((e == E1) || (e == E3)) bg = idx;
    if ((e == E2) || (e == E4)) bg = ~idx;
    return bg;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port test memory bus between the MBIST controller and the memory.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output write_read,
    output address,
    output wdata,
    input  rdata
  );

  modport slave (
    input  write_read,
    input  address,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/mbist_rd_cmp.sv
// Read-check pipeline, comparator and first-fail capture.
// MBIST_FAIL_CNT_EN adds a saturating mismatch counter.
module mbist_rd_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic                  in_bg,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [2:0]            in_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
`ifdef MBIST_FAIL_CNT_EN
  output logic [15:0]           fail_cnt,
`endif
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data
);

  logic                  pv  [RD_LATENCY];
  logic                  pbg [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pa  [RD_LATENCY];
  logic [2:0]            pe  [RD_LATENCY];
  logic                  mismatch;

  assign mismatch = pv[RD_LATENCY-1] &&
    (rdata != {DATA_WIDTH{pbg[RD_LATENCY-1]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pv[i]  <= 1'b0;
        pbg[i] <= 1'b0;
        pa[i]  <= '0;
        pe[i]  <= E0;
      end
    end else begin
      pv[0]  <= in_valid & ~clear;
      pbg[0] <= in_bg;
      pa[0]  <= in_addr;
      pe[0]  <= in_elem;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv[i]  <= pv[i-1] & ~clear;
        pbg[i] <= pbg[i-1];
        pa[i]  <= pa[i-1];
        pe[i]  <= pe[i-1];
      end
    end
  end

  // Diagnostics freeze on the first mismatch of a test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= E0;
      fail_data <= '0;
    end else if (clear) begin
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= E0;
      fail_data <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_addr <= pa[RD_LATENCY-1];
        fail_elem <= pe[RD_LATENCY-1];
        fail_data <= rdata;
      end
    end
  end

`ifdef MBIST_FAIL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (clear) begin
      fail_cnt <= '0;
    end else if (mismatch && (fail_cnt != 16'hFFFF)) begin
      fail_cnt <= fail_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller for a single-port memory with 1-cycle wdata lead.
// Optional MBIST_FAIL_CNT_EN exposes a saturating mismatch counter.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int ADDR_LAST  = 15,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_data,
`ifdef MBIST_FAIL_CNT_EN
  output logic [15:0]           fail_cnt,
`endif
  mbist_march_ctrl_if.master    mem
);

  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(ADDR_LAST);
  localparam int CW = $clog2(RD_LATENCY + 1) + 1;

  state_t                state, state_nx;
  logic [2:0]            elem;
  logic [2:0]            elem_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  opi;
  logic [CW-1:0]         dcnt;
  logic                  accept, run;
  logic                  op_last, addr_last;
  logic                  gen_op, gen_bg;

  logic                  cmd_valid, cmd_op, cmd_bg;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_elem;

  assign run       = (state == RUN);
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign busy      = run || (state == DRAIN);
  assign done      = (state == DONE);
  assign gen_op    = elem_op(elem, opi);
  assign gen_bg    = elem_bg(elem, opi);
  assign op_last   = opi || (elem_nops(elem) == 2'd1);
  assign addr_last = elem_down(elem) ? (addr == '0) : (addr == A_LAST);
  assign elem_nx   = elem + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN: if ((elem == E5) && addr_last && op_last) state_nx = DRAIN;
      DRAIN: if (dcnt == CW'(RD_LATENCY)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // All ops at one address complete before the address steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem <= E0;
      addr <= '0;
      opi  <= 1'b0;
      dcnt <= '0;
    end else if (accept) begin
      elem <= E0;
      addr <= '0;
      opi  <= 1'b0;
      dcnt <= '0;
    end else if (run) begin
      if (!op_last) begin
        opi <= 1'b1;
      end else begin
        opi <= 1'b0;
        if (!addr_last) begin
          addr <= elem_down(elem) ? addr - 1'b1 : addr + 1'b1;
        end else if (elem != E5) begin
          elem <= elem_nx;
          addr <= elem_down(elem_nx) ? A_LAST : '0;
        end
      end
    end else if (state == DRAIN) begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // Command stage: op/addr lag the generator so wdata leads by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_op    <= OP_R;
      cmd_bg    <= 1'b0;
      cmd_addr  <= '0;
      cmd_elem  <= E0;
    end else begin
      cmd_valid <= run;
      cmd_op    <= run ? gen_op : OP_R;
      cmd_bg    <= gen_bg;
      cmd_addr  <= run ? addr : '0;
      cmd_elem  <= elem;
    end
  end

  assign mem.write_read = cmd_op;
  assign mem.address    = cmd_addr;
  assign mem.wdata      = run ? {DATA_WIDTH{gen_bg}} : '0;

  mbist_rd_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_cmp (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .in_valid  (cmd_valid && (cmd_op == OP_R)),
    .in_bg     (cmd_bg),
    .in_addr   (cmd_addr),
    .in_elem   (cmd_elem),
    .rdata     (mem.rdata),
`ifdef MBIST_FAIL_CNT_EN
    .fail_cnt  (fail_cnt),
`endif
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl against a fault-injectable memory model.
module tb_mbist_march_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 4;
  localparam int N       = 16;
  localparam int NOPS    = 10 * N;
  localparam int RUN_CYC = NOPS + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_data;
`ifdef MBIST_FAIL_CNT_EN
  logic [15:0]   fail_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  mbist_march_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ADDR_LAST  (N - 1),
    .RD_LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_data (fail_data),
`ifdef MBIST_FAIL_CNT_EN
    .fail_cnt  (fail_cnt),
`endif
    .mem       (mif)
  );

  always #5 clk = ~clk;

  // 0 none, 1 TF 0->1 bit0 @5, 2 SA1 bit3 @0, 3 SA0 bit0 @7
  int            fault = 0;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] wd_q, rd_q;

  function automatic logic [DW-1:0] faulty(
    input logic [AW-1:0] a,
    input logic [DW-1:0] old,
    input logic [DW-1:0] nw
  );
    logic [DW-1:0] v;
    v = nw;
    if (fault == 1 && a == 4'd5) v[0] = nw[0] & old[0];
    if (fault == 2 && a == 4'd0) v[3] = 1'b1;
    if (fault == 3 && a == 4'd7) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      mif.rdata <= '0;
    end else begin
      wd_q      <= mif.wdata;
      rd_q      <= mem[mif.address];
      mif.rdata <= rd_q;
      if (mif.write_read)
        mem[mif.address] <= faulty(mif.address, mem[mif.address], wd_q);
    end
  end

  logic          exp_op [NOPS];
  logic [AW-1:0] exp_a  [NOPS];
  logic [DW-1:0] exp_d  [NOPS];

  task automatic build_seq;
    int n;
    int a;
    n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        case (e)
          0: begin
            exp_op[n] = 1'b1; exp_a[n] = AW'(a); exp_d[n] = 8'h00; n++;
          end
          1, 3: begin
            exp_op[n] = 1'b0; exp_a[n] = AW'(a); exp_d[n] = 8'h00; n++;
            exp_op[n] = 1'b1; exp_a[n] = AW'(a); exp_d[n] = 8'hFF; n++;
          end
          2, 4: begin
            exp_op[n] = 1'b0; exp_a[n] = AW'(a); exp_d[n] = 8'hFF; n++;
            exp_op[n] = 1'b1; exp_a[n] = AW'(a); exp_d[n] = 8'h00; n++;
          end
          default: begin
            exp_op[n] = 1'b0; exp_a[n] = AW'(a); exp_d[n] = 8'h00; n++;
          end
        endcase
      end
    end
  endtask

  int            cyc;
  int            fail_rise;
  logic          done0, fail0;
  logic [AW-1:0] fa0;
  logic [2:0]    fe0;
  logic [DW-1:0] fd0;

  task automatic run_march(input int flt, input int restart_at, input string tag);
    logic [DW-1:0] prev_wd;
    int k;
    fault = flt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done0 = done;
    fail0 = fail;
    fa0 = fail_addr;
    fe0 = fail_elem;
    fd0 = fail_data;
    cyc = 0;
    fail_rise = -1;
    prev_wd = '0;
    while (busy && cyc < 4 * NOPS) begin
      if (cyc >= 1 && cyc <= NOPS) begin
        k = cyc - 1;
        checks++;
        if (mif.write_read !== exp_op[k] || mif.address !== exp_a[k] ||
            (exp_op[k] && prev_wd !== exp_d[k])) begin
          errors++;
          $display("FAIL %s op%0d: wr=%0b addr=%0d wdata=%02h want wr=%0b addr=%0d wdata=%02h",
                   tag, k, mif.write_read, mif.address, prev_wd,
                   exp_op[k], exp_a[k], exp_d[k]);
        end
      end
      if (fail && fail_rise < 0) fail_rise = cyc;
      prev_wd = mif.wdata;
      start = (restart_at > 0) && (cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != RUN_CYC) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, cyc, RUN_CYC);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %0b want 1", tag, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %03b want 000", {busy, done, fail});
    end
    checks++;
    if ({fail_addr, fail_elem, fail_data} !== 15'd0) begin
      errors++;
      $display("FAIL reset_diag: got %0h want 0", {fail_addr, fail_elem, fail_data});
    end
    checks++;
    if ({mif.write_read, mif.address, mif.wdata} !== 13'd0) begin
      errors++;
      $display("FAIL reset_bus: got %0h want 0", {mif.write_read, mif.address, mif.wdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean;
    run_march(0, 0, "clean");
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL clean_fail: got %0b want 0", fail);
    end
    checks++;
    if (fail_rise != -1) begin
      errors++;
      $display("FAIL clean_rise: got %0d want -1", fail_rise);
    end
`ifdef MBIST_FAIL_CNT_EN
    checks++;
    if (fail_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clean_cnt: got %0d want 0", fail_cnt);
    end
`endif
  endtask

  task automatic test_transition_fault;
    run_march(1, 0, "tf");
    checks++;
    if ({fail, fail_elem, fail_addr, fail_data} !== {1'b1, 3'd2, 4'd5, 8'hFE}) begin
      errors++;
      $display("FAIL tf_diag: got fail=%0b elem=%0d addr=%0d data=%02h want 1 2 5 FE",
               fail, fail_elem, fail_addr, fail_data);
    end
    checks++;
    if (fail_rise != 62) begin
      errors++;
      $display("FAIL tf_rise: got %0d want 62", fail_rise);
    end
  endtask

  task automatic test_stuck_at1;
    run_march(2, 0, "sa1");
    checks++;
    if ({fail, fail_elem, fail_addr, fail_data} !== {1'b1, 3'd1, 4'd0, 8'h08}) begin
      errors++;
      $display("FAIL sa1_diag: got fail=%0b elem=%0d addr=%0d data=%02h want 1 1 0 08",
               fail, fail_elem, fail_addr, fail_data);
    end
    checks++;
    if (fail_rise != 20) begin
      errors++;
      $display("FAIL sa1_rise: got %0d want 20", fail_rise);
    end
`ifdef MBIST_FAIL_CNT_EN
    checks++;
    if (fail_cnt !== 16'd3) begin
      errors++;
      $display("FAIL sa1_cnt: got %0d want 3", fail_cnt);
    end
`endif
  endtask

  task automatic test_stuck_at0;
    run_march(3, 0, "sa0");
    checks++;
    if ({fail, fail_elem, fail_addr, fail_data} !== {1'b1, 3'd2, 4'd7, 8'hFE}) begin
      errors++;
      $display("FAIL sa0_diag: got fail=%0b elem=%0d addr=%0d data=%02h want 1 2 7 FE",
               fail, fail_elem, fail_addr, fail_data);
    end
    checks++;
    if (fail_rise != 66) begin
      errors++;
      $display("FAIL sa0_rise: got %0d want 66", fail_rise);
    end
`ifdef MBIST_FAIL_CNT_EN
    checks++;
    if (fail_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sa0_cnt: got %0d want 2", fail_cnt);
    end
`endif
  endtask

  task automatic test_restart_from_done;
    run_march(0, 0, "redo");
    checks++;
    if ({done0, fail0, fa0, fe0, fd0} !== 17'd0) begin
      errors++;
      $display("FAIL redo_clear: got done=%0b fail=%0b addr=%0d elem=%0d data=%02h want 0",
               done0, fail0, fa0, fe0, fd0);
    end
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL redo_fail: got %0b want 0", fail);
    end
  endtask

  task automatic test_start_in_run;
    run_march(0, 20, "restart");
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL restart_fail: got %0b want 0", fail);
    end
  endtask

  task automatic test_reset_mid_run;
    fault = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, fail, fail_addr, fail_elem, fail_data,
         mif.write_read, mif.address, mif.wdata} !== 31'd0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%0b done=%0b fail=%0b wr=%0b addr=%0d wdata=%02h want 0",
               busy, done, fail, mif.write_read, mif.address, mif.wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_march(0, 0, "rerun");
    checks++;
    if ({fail, fail_addr, fail_elem, fail_data} !== 16'd0) begin
      errors++;
      $display("FAIL rerun_diag: got fail=%0b addr=%0d elem=%0d data=%02h want 0",
               fail, fail_addr, fail_elem, fail_data);
    end
  endtask

  initial begin
    build_seq();
    test_reset();
    test_clean();
    test_transition_fault();
    test_stuck_at1();
    test_stuck_at0();
    test_restart_from_done();
    test_start_in_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
